// File: rtl/a2d_arb.sv
// Round-robin arbiter/sequencer sharing one A2D converter among NREQ requesters:
// grant, optional channel settle, start pulse, watchdog-bounded wait, one-hot result.
module a2d_arb #(
   parameter int NREQ       = 4,
   parameter int SETTLE_CYC = 32,
   parameter int TMO_CYC    = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] req_chnnl,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   res_vld,
   output logic [11:0]       res,
   output logic              tmo_err,
   output logic              busy,
   output logic [2:0]        chnnl,
   output logic              start_conv,
   input  logic              cnv_cmplt,
   input  logic [11:0]       A2D_res
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int TW = $clog2(TMO_CYC);

   typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr, ptr_nx;
   logic [SW-1:0]   cnt, cnt_nx;
   logic [TW-1:0]   wdog, wdog_nx;
   logic            tmo, tmo_nx;
   logic            chnnl_vld, vld_nx;
   logic [NREQ-1:0] gnt_nx, res_vld_nx;
   logic [2:0]      chnnl_nx;
   logic [11:0]     res_nx;
   logic            tmo_err_nx, busy_nx, start_nx;

   logic            sel_hit;
   logic [PW-1:0]   sel_idx;
   logic [2:0]      sel_ch;

   // Walk from the highest offset down so the nearest set bit at or after ptr wins.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_ch  = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NREQ]) begin
            sel_hit = 1'b1;
            sel_idx = PW'((int'(ptr) + k) % NREQ);
            sel_ch  = req_chnnl[3*((int'(ptr) + k) % NREQ) +: 3];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         wdog       <= '0;
         tmo        <= 1'b0;
         chnnl_vld  <= 1'b0;
         gnt        <= '0;
         chnnl      <= '0;
         res        <= '0;
         res_vld    <= '0;
         tmo_err    <= 1'b0;
         busy       <= 1'b0;
         start_conv <= 1'b0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         cnt        <= cnt_nx;
         wdog       <= wdog_nx;
         tmo        <= tmo_nx;
         chnnl_vld  <= vld_nx;
         gnt        <= gnt_nx;
         chnnl      <= chnnl_nx;
         res        <= res_nx;
         res_vld    <= res_vld_nx;
         tmo_err    <= tmo_err_nx;
         busy       <= busy_nx;
         start_conv <= start_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      wdog_nx  = wdog;
      tmo_nx   = tmo;
      vld_nx   = chnnl_vld;
      gnt_nx   = gnt;
      chnnl_nx = chnnl;
      res_nx   = res;
      case (state)
         IDLE: if (sel_hit) begin
            gnt_nx          = '0;
            gnt_nx[sel_idx] = 1'b1;
            chnnl_nx        = sel_ch;
            ptr_nx          = PW'((int'(sel_idx) + 1) % NREQ);
            cnt_nx          = '0;
            // Mux already parked on this channel after a good conversion: no settle needed.
            if (SETTLE_CYC == 0 || (chnnl_vld && sel_ch == chnnl)) state_nx = START;
            else                                                   state_nx = SETTLE;
         end
         SETTLE: begin
            if (cnt == SW'(SETTLE_CYC-1)) state_nx = START;
            else                          cnt_nx   = cnt + 1'b1;
         end
         START: begin
            wdog_nx  = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (cnv_cmplt) begin
               res_nx   = A2D_res;
               vld_nx   = 1'b1;
               tmo_nx   = 1'b0;
               state_nx = DONE;
            end else if (wdog == TW'(TMO_CYC-1)) begin
               res_nx   = '0;
               vld_nx   = 1'b0;
               tmo_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               wdog_nx  = wdog + 1'b1;
            end
         end
         DONE: begin
            gnt_nx   = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      start_nx   = (state_nx == START);
      busy_nx    = (state_nx != IDLE);
      res_vld_nx = (state_nx == DONE) ? gnt_nx : '0;
      tmo_err_nx = (state_nx == DONE) && tmo_nx;
   end

endmodule

// File: tb/tb_a2d_arb.sv
// Scoreboard bench for a2d_arb: a transaction-level model predicts grant, settle/skip
// latency and result; a monitor pops expectations on every res_vld pulse.
module tb_a2d_arb;
   localparam int NREQ = 4, SETTLE = 32, TMO = 1024;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  req;
   logic [11:0] req_chnnl;
   logic [3:0]  gnt, res_vld;
   logic [11:0] res;
   logic        tmo_err, busy, start_conv, cnv_cmplt;
   logic [2:0]  chnnl;
   logic [11:0] A2D_res;

   a2d_arb #(.NREQ(NREQ), .SETTLE_CYC(SETTLE), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl), .gnt(gnt),
      .res_vld(res_vld), .res(res), .tmo_err(tmo_err), .busy(busy), .chnnl(chnnl),
      .start_conv(start_conv), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res));

   always #5 clk = ~clk;

   typedef struct packed {logic [3:0] vld; logic [11:0] res; logic tmo;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int checks = 0, errors = 0;
   int mptr;
   bit mvld;
   logic [2:0] mch;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (res_vld != 0 || tmo_err)) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: res_vld %0h with empty scoreboard", res_vld);
         end else begin
            mon_e = sb.pop_front();
            chk("res_vld", res_vld, mon_e.vld);
            chk("res", res, mon_e.res);
            chk("tmo_err", tmo_err, mon_e.tmo);
         end
      end
   end

   // d < 0: A2D never answers (timeout); otherwise cnv_cmplt in WAIT cycle d.
   task automatic do_txn(input logic [3:0] r, input logic [11:0] chs, input int d,
                         input logic [11:0] val, output int gi, output int lat);
      int w, n;
      logic [2:0] ch;
      bit skip, tmo;
      exp_t e;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         int j = (mptr + k) % NREQ;
         if (r[j]) begin w = j; break; end
      end
      mptr = (w + 1) % NREQ;
      ch   = chs[3*w +: 3];
      skip = mvld && (ch == mch);
      mch  = ch;
      tmo  = (d < 0);
      mvld = !tmo;
      e.vld = 4'(1 << w);
      e.res = tmo ? 12'h000 : val;
      e.tmo = tmo;
      sb.push_back(e);

      req = r; req_chnnl = chs;
      @(negedge clk);
      gi = -1;
      for (int k = 0; k < NREQ; k++) if (gnt[k]) gi = k;
      chk("gnt", gnt, 1 << w);
      chk("chnnl", chnnl, ch);
      chk("busy", busy, 1);
      n = 1;
      while (!start_conv && n < 200) begin @(negedge clk); n++; end
      lat = n;
      chk("start_lat", n, skip ? 1 : SETTLE + 1);
      // Stray completion during START must be ignored.
      if ($urandom_range(3) == 0) begin cnv_cmplt = 1'b1; A2D_res = 12'($urandom); end
      @(negedge clk);
      chk("start_pulse_len", start_conv, 0);
      cnv_cmplt = 1'b0;
      if (d >= 0) begin
         repeat (d) @(negedge clk);
         cnv_cmplt = 1'b1; A2D_res = val;
         @(negedge clk);
         cnv_cmplt = 1'b0; A2D_res = 12'($urandom);
      end
      n = 0;
      while (res_vld == 0 && n < 1100) begin @(negedge clk); n++; end
      chk("done_lat", n, tmo ? TMO : 0);
      req = '0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int gi, lat, n, d, p;
      logic [11:0] chs;
      req = '0; req_chnnl = '0; cnv_cmplt = 1'b0; A2D_res = '0;
      mptr = 0; mvld = 0; mch = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);     chk("rst_res_vld", res_vld, 0);
      chk("rst_res", res, 0);     chk("rst_tmo_err", tmo_err, 0);
      chk("rst_busy", busy, 0);   chk("rst_chnnl", chnnl, 0);
      chk("rst_start", start_conv, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_txn(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, $urandom_range(8), 12'($urandom), gi, lat);
         chk("rr_order", gi, i % 4);
      end

      do_txn(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 6, 12'hA5C, gi, lat);
      chk("single_start_cycle", lat, 33);

      do_txn(4'b0001, 12'd3, 2, 12'h311, gi, lat);
      do_txn(4'b0001, 12'd3, 0, 12'h312, gi, lat);
      chk("skip_start_cycle", lat, 1);

      do_txn(4'b0001, 12'd3, -1, 12'hFFF, gi, lat);
      do_txn(4'b0001, 12'd3, 1, 12'h5A5, gi, lat);
      chk("post_tmo_settle", lat, 33);

      do_txn(4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, TMO - 1, 12'h123, gi, lat);

      req = 4'b0010; req_chnnl = {3'd0, 3'd0, 3'd2, 3'd0};
      n = 0;
      while (!start_conv && n < 200) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", gnt, 0);     chk("mid_rst_res", res, 0);
      chk("mid_rst_busy", busy, 0);   chk("mid_rst_chnnl", chnnl, 0);
      chk("mid_rst_start", start_conv, 0);
      chk("mid_rst_vld", res_vld, 0); chk("mid_rst_tmo", tmo_err, 0);
      req = '0; mptr = 0; mvld = 0; mch = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_txn(4'b1001, {3'd1, 3'd0, 3'd0, 3'd7}, 3, 12'h0F0, gi, lat);
      chk("post_rst_first", gi, 0);

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < NREQ; k++) chs[3*k +: 3] = 3'($urandom_range(0, 3));
         p = $urandom_range(0, 24);
         d = (p == 0) ? -1 : (p == 1) ? TMO - 1 : $urandom_range(0, 10);
         do_txn(4'($urandom_range(1, 15)), chs, d, 12'($urandom), gi, lat);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
